perf_event_monitor: RTL and testbench



---
 rtl/perf_event_monitor.sv | 94 +++++++++
 tb/tb_perf_event_monitor.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_event_monitor.sv
// Pipeline performance monitor: a cycle counter plus NUM_EV event counters
// over a bounded window, with pause, wrap/saturate, sticky overflow and registered readout.
module perf_event_monitor #(
   parameter int NUM_EV     = 4,
   parameter int CNT_W      = 32,
   parameter int MAX_CYCLES = 30,
   parameter int SATURATE   = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              freeze_i,
   input  logic              clear_i,
   input  logic [NUM_EV-1:0] event_i,
   input  logic [3:0]        rd_sel_i,
   output logic [CNT_W-1:0]  rd_data_o,
   output logic [NUM_EV:0]   ovf_o,
   output logic              running_o,
   output logic              done_o
);

   // state   | meaning
   // ST_IDLE | counters cleared or held, waiting for start_i
   // ST_RUN  | counting on every cycle where freeze_i is low
   // ST_DONE | window expired, counters hold until rst_i/clear_i

   localparam int WIN_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt [NUM_EV+1];
   logic [WIN_W-1:0] win_left;
   logic             active;
   logic [NUM_EV:0]  hit;
   logic [CNT_W-1:0] rd_mux;

   assign active    = (state == ST_RUN) && !freeze_i;
   // Slot 0 is the cycle counter, which counts on every active cycle.
   assign hit       = {event_i, 1'b1} & {(NUM_EV+1){active}};
   assign running_o = (state == ST_RUN);
   assign done_o    = (state == ST_DONE);

   always_comb begin
      rd_mux = '0;
      for (int k = 0; k <= NUM_EV; k++) begin
         if (rd_sel_i == 4'(k)) rd_mux = cnt[k];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         state     <= ST_IDLE;
         win_left  <= '0;
         ovf_o     <= '0;
         rd_data_o <= '0;
         for (int k = 0; k <= NUM_EV; k++) cnt[k] <= '0;
      end else begin
         rd_data_o <= rd_mux;
         for (int k = 0; k <= NUM_EV; k++) begin
            if (hit[k]) begin
               if (&cnt[k]) begin
                  ovf_o[k] <= 1'b1;
                  if (SATURATE == 0) cnt[k] <= '0;
               end else begin
                  cnt[k] <= cnt[k] + CNT_W'(1);
               end
            end
         end
         // Window is a down-counter so it does not depend on CNT_W wrapping.
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  state    <= ST_RUN;
                  win_left <= WIN_W'(MAX_CYCLES);
               end
            end
            ST_RUN: begin
               if (active && (MAX_CYCLES != 0)) begin
                  win_left <= win_left - WIN_W'(1);
                  if (win_left == WIN_W'(1)) state <= ST_DONE;
               end
            end
            ST_DONE: ;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_perf_event_monitor.sv
// Self-checking bench for perf_event_monitor: directed scenarios plus
// randomized traffic checked against a count-based reference model.
module tb_perf_event_monitor;

   localparam int NE = 4;
   localparam int W  = 32;
   localparam int MC = 30;
   localparam longint unsigned CMAX = 64'hFFFF_FFFF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, start, freeze, clear;
   logic [NE-1:0] ev;
   logic [3:0]    sel;
   logic [W-1:0]  rd;
   logic [NE:0]   ovf;
   logic          running, done;

   logic          s_rst, s_start, s_freeze, s_clear;
   logic [1:0]    s_ev;
   logic [3:0]    s_sel;
   logic [7:0]    w_rd, t_rd;
   logic [2:0]    w_ovf, t_ovf;
   logic          w_run, w_done, t_run, t_done;

   perf_event_monitor #(.NUM_EV(NE), .CNT_W(W), .MAX_CYCLES(MC), .SATURATE(0)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .freeze_i(freeze), .clear_i(clear),
      .event_i(ev), .rd_sel_i(sel), .rd_data_o(rd), .ovf_o(ovf),
      .running_o(running), .done_o(done));

   perf_event_monitor #(.NUM_EV(2), .CNT_W(8), .MAX_CYCLES(0), .SATURATE(0)) dut_wrap (
      .clk_i(clk), .rst_i(s_rst), .start_i(s_start), .freeze_i(s_freeze), .clear_i(s_clear),
      .event_i(s_ev), .rd_sel_i(s_sel), .rd_data_o(w_rd), .ovf_o(w_ovf),
      .running_o(w_run), .done_o(w_done));

   perf_event_monitor #(.NUM_EV(2), .CNT_W(8), .MAX_CYCLES(0), .SATURATE(1)) dut_sat (
      .clk_i(clk), .rst_i(s_rst), .start_i(s_start), .freeze_i(s_freeze), .clear_i(s_clear),
      .event_i(s_ev), .rd_sel_i(s_sel), .rd_data_o(t_rd), .ovf_o(t_ovf),
      .running_o(t_run), .done_o(t_done));

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: phase 0 idle, 1 measuring, 2 finished.
   int              m_st;
   longint unsigned m_cnt [NE+1];
   logic [NE:0]     m_ovf;
   longint unsigned m_rd;

   task automatic step(input logic r, input logic cl, input logic st, input logic fr,
                       input logic [NE-1:0] e, input logic [3:0] s);
      rst = r; clear = cl; start = st; freeze = fr; ev = e; sel = s;
      @(posedge clk);
      if (r || cl) begin
         m_st = 0; m_ovf = '0; m_rd = 0;
         for (int k = 0; k <= NE; k++) m_cnt[k] = 0;
      end else begin
         m_rd = (s <= NE) ? m_cnt[s] : 0;
         if (m_st == 0) begin
            if (st) m_st = 1;
         end else if (m_st == 1 && !fr) begin
            for (int k = 0; k <= NE; k++) begin
               if (k == 0 || e[k-1]) begin
                  if (m_cnt[k] == CMAX) begin
                     m_ovf[k] = 1'b1;
                     m_cnt[k] = 0;
                  end else begin
                     m_cnt[k] = m_cnt[k] + 1;
                  end
               end
            end
            if (MC != 0 && m_cnt[0] == MC) m_st = 2;
         end
      end
      #1;
   endtask

   task automatic test_reset;
      step(1, 0, 1, 0, '1, 0);
      step(1, 0, 0, 0, '0, 0);
      n_chk++;
      if (rd !== '0) begin n_fail++; $display("FAIL reset_rd got %0h want 0", rd); end
      n_chk++;
      if (ovf !== '0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
      n_chk++;
      if (running !== 1'b0 || done !== 1'b0) begin
         n_fail++; $display("FAIL reset_state got run=%b done=%b want 0 0", running, done);
      end
   endtask

   task automatic test_window;
      step(1, 0, 0, 0, '0, 0);
      step(0, 0, 1, 0, '0, 0);
      for (int i = 0; i < 30; i++) begin
         step(0, 0, 0, 0, (i % 3 == 0) ? 4'b0001 : 4'b0000, 0);
         n_chk++;
         if (done !== (i == 29) || running !== (i != 29)) begin
            n_fail++; $display("FAIL window_state i=%0d got run=%b done=%b", i, running, done);
         end
      end
      for (int i = 0; i < 10; i++) begin
         step(0, 0, i[0], 0, 4'($urandom), 4'(i % 2));
         n_chk++;
         if (rd !== W'((i % 2 == 0) ? 30 : 10) || rd !== W'(m_rd) || done !== 1'b1) begin
            n_fail++; $display("FAIL window_hold i=%0d got rd=%0d done=%b want %0d", i, rd, done,
                               (i % 2 == 0) ? 30 : 10);
         end
      end
   endtask

   task automatic test_freeze_and_sweep;
      logic [3:0] sels [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd15};
      step(1, 0, 0, 0, '0, 0);
      step(0, 0, 1, 0, '1, 0);
      for (int i = 0; i < 34; i++) step(0, 0, 0, (i >= 10 && i < 15), '1, 0);
      n_chk++;
      if (done !== 1'b0 || running !== 1'b1) begin
         n_fail++; $display("FAIL freeze_extend got run=%b done=%b want 1 0", running, done);
      end
      step(0, 0, 0, 0, '1, 0);
      n_chk++;
      if (done !== 1'b1) begin n_fail++; $display("FAIL freeze_done got %b want 1", done); end
      foreach (sels[j]) begin
         step(0, 0, 0, 0, 4'($urandom), sels[j]);
         n_chk++;
         if (rd !== W'((sels[j] <= NE) ? 30 : 0) || rd !== W'(m_rd)) begin
            n_fail++; $display("FAIL sweep sel=%0d got %0d want %0d", sels[j], rd,
                               (sels[j] <= NE) ? 30 : 0);
         end
      end
   endtask

   task automatic test_clear;
      step(1, 0, 0, 0, '0, 0);
      step(0, 0, 1, 0, '0, 0);
      for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 4'($urandom), 0);
      step(0, 1, 1, 0, '1, 0);
      n_chk++;
      if (running !== 1'b0 || done !== 1'b0 || ovf !== '0 || rd !== '0) begin
         n_fail++; $display("FAIL clear_state got run=%b done=%b ovf=%b rd=%0d", running, done, ovf, rd);
      end
      for (int s = 0; s <= NE; s++) begin
         step(0, 0, 0, 0, '1, 4'(s));
         n_chk++;
         if (rd !== '0 || running !== 1'b0) begin
            n_fail++; $display("FAIL clear_cnt sel=%0d got rd=%0d run=%b want 0 0", s, rd, running);
         end
      end
      step(0, 0, 1, 0, '1, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 4'b0101, 0);
      for (int s = 0; s < 3; s++) begin
         step(0, 0, 0, 1, '1, 4'(s));
         n_chk++;
         if (rd !== W'((s == 2) ? 0 : 6) || rd !== W'(m_rd)) begin
            n_fail++; $display("FAIL restart sel=%0d got %0d want %0d", s, rd, (s == 2) ? 0 : 6);
         end
      end
   endtask

   task automatic test_rst_clear_done;
      step(1, 0, 0, 0, '0, 0);
      step(0, 0, 1, 0, '0, 0);
      for (int i = 0; i < MC; i++) step(0, 0, 0, 0, '1, 0);
      n_chk++;
      if (done !== 1'b1) begin n_fail++; $display("FAIL pre_rst_done got %b want 1", done); end
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 1, 0, '1, 0);
         n_chk++;
         if (running !== 1'b0 || done !== 1'b0 || rd !== '0) begin
            n_fail++; $display("FAIL rst_hold i=%0d got run=%b done=%b rd=%0d", i, running, done, rd);
         end
      end
      step(0, 0, 1, 0, '1, 0);
      n_chk++;
      if (running !== 1'b1) begin n_fail++; $display("FAIL rst_release got run=%b want 1", running); end
      step(0, 0, 0, 1, '1, 0);
      n_chk++;
      if (rd !== '0) begin n_fail++; $display("FAIL rst_release_cnt got %0d want 0", rd); end
   endtask

   task automatic test_random;
      step(1, 0, 0, 0, '0, 0);
      for (int i = 0; i < 500; i++) begin
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 79) == 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
              4'($urandom), 4'($urandom_range(0, 6)));
         n_chk++;
         if (rd !== W'(m_rd) || ovf !== m_ovf || running !== (m_st == 1) || done !== (m_st == 2)) begin
            n_fail++;
            $display("FAIL random i=%0d got rd=%0d ovf=%b run=%b done=%b want rd=%0d ovf=%b st=%0d",
                     i, rd, ovf, running, done, m_rd, m_ovf, m_st);
         end
      end
   endtask

   task automatic test_overflow;
      int n;
      s_rst = 1; s_start = 0; s_freeze = 0; s_clear = 0; s_ev = '0; s_sel = 4'd2;
      @(posedge clk); #1;
      s_rst = 0; s_start = 1;
      @(posedge clk); #1;
      s_start = 0; s_ev = 2'b10;
      for (n = 1; n <= 260; n++) begin
         @(posedge clk); #1;
         if (n == 255 || n == 256 || n == 260) begin
            n_chk++;
            if (w_ovf[2] !== (n >= 256) || t_ovf[2] !== (n >= 256)) begin
               n_fail++; $display("FAIL ovf_bit n=%0d got wrap=%b sat=%b want %b", n, w_ovf[2],
                                  t_ovf[2], (n >= 256));
            end
         end
      end
      s_freeze = 1;
      for (int s = 2; s >= 0; s--) begin
         s_sel = 4'(s);
         @(posedge clk); #1;
         n_chk++;
         if (w_rd !== 8'((s == 1) ? 0 : 260 % 256) || t_rd !== 8'((s == 1) ? 0 : 255)) begin
            n_fail++; $display("FAIL ovf_value sel=%0d got wrap=%0d sat=%0d want %0d %0d", s, w_rd,
                               t_rd, (s == 1) ? 0 : 4, (s == 1) ? 0 : 255);
         end
      end
      n_chk++;
      if (w_ovf !== 3'b101 || t_ovf !== 3'b101 || w_run !== 1'b1 || t_done !== 1'b0) begin
         n_fail++; $display("FAIL ovf_flags got wrap=%b sat=%b run=%b done=%b want 101 101 1 0",
                            w_ovf, t_ovf, w_run, t_done);
      end
   endtask

   initial begin
      rst = 1; clear = 0; start = 0; freeze = 0; ev = '0; sel = '0;
      s_rst = 1; s_clear = 0; s_start = 0; s_freeze = 0; s_ev = '0; s_sel = '0;
      m_st = 0; m_ovf = '0; m_rd = 0;
      for (int k = 0; k <= NE; k++) m_cnt[k] = 0;
      test_reset();
      test_window();
      test_freeze_and_sweep();
      test_clear();
      test_rst_clear_done();
      test_overflow();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
